// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: integer and FP result offers plus the single
// register-file write port driven by wb_arbiter.
interface wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              int_valid;
    logic              int_ready;
    logic [ADDR_W-1:0] int_dst;
    logic [DATA_W-1:0] int_data;
    logic              fp_valid;
    logic              fp_ready;
    logic [ADDR_W-1:0] fp_dst;
    logic [DATA_W-1:0] fp_data;
    logic              wb_write;
    logic              wb_fp_write;
    logic [ADDR_W-1:0] wb_dst;
    logic [DATA_W-1:0] wb_rd;
    logic [CW-1:0]     fp_count;

    modport master (
        output int_valid, int_dst, int_data,
        output fp_valid, fp_dst, fp_data,
        input  int_ready, fp_ready,
        input  wb_write, wb_fp_write, wb_dst, wb_rd, fp_count
    );

    modport slave (
        input  int_valid, int_dst, int_data,
        input  fp_valid, fp_dst, fp_data,
        output int_ready, fp_ready,
        output wb_write, wb_fp_write, wb_dst, wb_rd, fp_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one registered write port shared by 1-cycle int results
// and FIFO-buffered FP results. WB_FP_BYPASS_EN lets FP skip an idle FIFO.
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [ADDR_W-1:0] mem_dst_q  [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wb_write_q, wb_write_d;
    logic              wb_fp_write_q, wb_fp_write_d;
    logic [ADDR_W-1:0] wb_dst_q, wb_dst_d;
    logic [DATA_W-1:0] wb_rd_q, wb_rd_d;
    logic              full, empty, push, pop, bypass;

    always_comb begin
        full   = count_q == CW'(DEPTH);
        empty  = count_q == '0;
        pop    = full || (!bus.int_valid && !empty);
        push   = bus.fp_valid && !full;
        bypass = 1'b0;
`ifdef WB_FP_BYPASS_EN
        bypass = push && empty && !bus.int_valid;
        push   = push && !bypass;
`endif
        wb_write_d    = 1'b0;
        wb_fp_write_d = 1'b0;
        wb_dst_d      = wb_dst_q;
        wb_rd_d       = wb_rd_q;
        if (pop) begin
            wb_fp_write_d = 1'b1;
            wb_dst_d      = mem_dst_q[rd_ptr_q];
            wb_rd_d       = mem_data_q[rd_ptr_q];
        end else if (bus.int_valid) begin
            // r0 is hardwired: slot is consumed but nothing is written
            wb_write_d = |bus.int_dst;
            wb_dst_d   = bus.int_dst;
            wb_rd_d    = bus.int_data;
        end else if (bypass) begin
            wb_fp_write_d = 1'b1;
            wb_dst_d      = bus.fp_dst;
            wb_rd_d       = bus.fp_data;
        end
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            wb_write_q    <= 1'b0;
            wb_fp_write_q <= 1'b0;
            wb_dst_q      <= '0;
            wb_rd_q       <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            wb_write_q    <= wb_write_d;
            wb_fp_write_q <= wb_fp_write_d;
            wb_dst_q      <= wb_dst_d;
            wb_rd_q       <= wb_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_data_q[wr_ptr_q] <= bus.fp_data;
            mem_dst_q[wr_ptr_q]  <= bus.fp_dst;
        end
    end

    assign bus.int_ready   = !full;
    assign bus.fp_ready    = !full;
    assign bus.wb_write    = wb_write_q;
    assign bus.wb_fp_write = wb_fp_write_q;
    assign bus.wb_dst      = wb_dst_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.fp_count    = count_q;
endmodule
